// File: rtl/buzzer_tone_gen.sv
// Square-wave buzzer driver: a restoring divider turns a tone frequency into a half-period count.
// Optional build macro TONE_VOLUME_EN adds a volume[1:0] input that PWM-gates the high phase.
module buzzer_tone_gen #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned FREQ_W = 12,
    parameter int unsigned CNT_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] frequency,
    input  logic              enable,
`ifdef TONE_VOLUME_EN
    input  logic [1:0]        volume,
`endif
    output logic              buzzer,
    output logic              busy,
    output logic [CNT_W-1:0]  half_period
);

    localparam int unsigned DVD_W  = CNT_W + 1;
    localparam int unsigned DIV_W  = FREQ_W + 1;
    localparam int unsigned REM_W  = FREQ_W + 2;
    localparam int unsigned STEP_W = $clog2(CNT_W + 2);

    localparam logic [DVD_W-1:0]  DIVIDEND  = DVD_W'(CLK_HZ);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W);

    typedef enum logic [1:0] {
        S_SILENT = 2'd0,
        S_CALC   = 2'd1,
        S_PLAY   = 2'd2
    } state_t;

    state_t              r_state;
    logic [FREQ_W-1:0]   r_freq_q;
    logic [DVD_W-1:0]    r_dvd;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_rem;
    logic [CNT_W-1:0]    r_quo;
    logic [STEP_W-1:0]   r_step;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_square;
    logic                r_buzzer;
    logic                r_busy;
    logic [CNT_W-1:0]    r_half;

    state_t              w_state_nxt;
    logic [FREQ_W-1:0]   w_freq_q_nxt;
    logic [DVD_W-1:0]    w_dvd_nxt;
    logic [DIV_W-1:0]    w_div_nxt;
    logic [DIV_W-1:0]    w_rem_nxt;
    logic [CNT_W-1:0]    w_quo_nxt;
    logic [STEP_W-1:0]   w_step_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_square_nxt;
    logic                w_buzzer_nxt;
    logic                w_busy_nxt;
    logic [CNT_W-1:0]    w_half_nxt;

    logic [REM_W-1:0]    w_rem_shift;
    logic                w_fits;
    logic [DIV_W-1:0]    w_rem_sub;
    logic [CNT_W-1:0]    w_quo_shift;

    // One restoring-division step: bring down the next dividend bit, subtract if it fits.
    assign w_rem_shift = {r_rem, r_dvd[DVD_W-1]};
    assign w_fits      = (w_rem_shift >= REM_W'(r_div));
    assign w_rem_sub   = DIV_W'(w_rem_shift - REM_W'(r_div));
    assign w_quo_shift = CNT_W'({r_quo, w_fits});

`ifdef TONE_VOLUME_EN
    logic [3:0] r_pwm;
    logic [3:0] w_pwm_nxt;
    logic [4:0] w_duty;

    assign w_pwm_nxt = r_pwm + 4'd1;

    always_comb begin
        w_duty = 5'd0;
        case (volume)
            2'd0:    w_duty = 5'd0;
            2'd1:    w_duty = 5'd4;
            2'd2:    w_duty = 5'd8;
            default: w_duty = 5'd16;
        endcase
    end

    assign w_buzzer_nxt = w_square_nxt & ({1'b0, w_pwm_nxt} < w_duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= 4'd0;
        end else begin
            r_pwm <= w_pwm_nxt;
        end
    end
`else
    assign w_buzzer_nxt = w_square_nxt;
`endif

    // Next-state logic; a frequency change overrides whatever the FSM was doing.
    always_comb begin
        w_state_nxt  = r_state;
        w_freq_q_nxt = r_freq_q;
        w_dvd_nxt    = r_dvd;
        w_div_nxt    = r_div;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_step_nxt   = r_step;
        w_cnt_nxt    = r_cnt;
        w_square_nxt = r_square;
        w_half_nxt   = r_half;

        if (frequency != r_freq_q) begin
            w_freq_q_nxt = frequency;
            w_cnt_nxt    = '0;
            w_square_nxt = 1'b0;
            if (frequency == '0) begin
                w_state_nxt = S_SILENT;
            end else begin
                w_state_nxt = S_CALC;
                w_dvd_nxt   = DIVIDEND;
                w_div_nxt   = {frequency, 1'b0};
                w_rem_nxt   = '0;
                w_quo_nxt   = '0;
                w_step_nxt  = '0;
            end
        end else begin
            case (r_state)
                S_SILENT: begin
                    w_cnt_nxt    = '0;
                    w_square_nxt = 1'b0;
                end
                S_CALC: begin
                    w_dvd_nxt    = DVD_W'({r_dvd, 1'b0});
                    w_rem_nxt    = w_fits ? w_rem_sub : DIV_W'(w_rem_shift);
                    w_quo_nxt    = w_quo_shift;
                    w_step_nxt   = r_step + STEP_W'(1);
                    w_cnt_nxt    = '0;
                    w_square_nxt = 1'b0;
                    if (r_step == LAST_STEP) begin
                        w_half_nxt  = w_quo_shift;
                        w_state_nxt = S_PLAY;
                    end
                end
                S_PLAY: begin
                    // Muting holds the phase at its start so re-enable begins a fresh low half.
                    if (!enable) begin
                        w_cnt_nxt    = '0;
                        w_square_nxt = 1'b0;
                    end else if (r_cnt == r_half - CNT_W'(1)) begin
                        w_cnt_nxt    = '0;
                        w_square_nxt = ~r_square;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt  = S_SILENT;
                    w_cnt_nxt    = '0;
                    w_square_nxt = 1'b0;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == S_CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_SILENT;
            r_freq_q <= '0;
            r_dvd    <= '0;
            r_div    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_step   <= '0;
            r_cnt    <= '0;
            r_square <= 1'b0;
            r_buzzer <= 1'b0;
            r_busy   <= 1'b0;
            r_half   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_freq_q <= w_freq_q_nxt;
            r_dvd    <= w_dvd_nxt;
            r_div    <= w_div_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_step   <= w_step_nxt;
            r_cnt    <= w_cnt_nxt;
            r_square <= w_square_nxt;
            r_buzzer <= w_buzzer_nxt;
            r_busy   <= w_busy_nxt;
            r_half   <= w_half_nxt;
        end
    end

    assign buzzer      = r_buzzer;
    assign busy        = r_busy;
    assign half_period = r_half;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed plus randomized bench for buzzer_tone_gen, checked against arithmetic expectations.
module tb_buzzer_tone_gen;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned FREQ_W = 12;
    localparam int unsigned CNT_W  = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [FREQ_W-1:0] frequency = '0;
    logic              enable = 1'b1;
    logic              buzzer;
    logic              busy;
    logic [CNT_W-1:0]  half_period;

    int checks = 0;
    int errors = 0;
    bit saw_stale_half = 1'b0;

    buzzer_tone_gen #(
        .CLK_HZ(CLK_HZ),
        .FREQ_W(FREQ_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frequency  (frequency),
        .enable     (enable),
`ifdef TONE_VOLUME_EN
        .volume     (2'd3),
`endif
        .buzzer     (buzzer),
        .busy       (busy),
        .half_period(half_period)
    );

    always #5 clk = ~clk;

    // The aborted 262 Hz computation would yield 1908; it must never be published.
    always @(negedge clk) if (half_period == 20'd1908) saw_stale_half = 1'b1;

    function automatic int model_half(input int f);
        return CLK_HZ / (2 * f);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge: apply a note, then check CALC length, result, first rise, and period.
    task automatic run_note(input string tag, input int f);
        int n;
        int bad;
        int r;
        int p;
        int h;
        int lim;
        h   = model_half(f);
        lim = 4 * h + 20;
        frequency = FREQ_W'(f);
        n   = 0;
        bad = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (buzzer !== 1'b0) bad++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, n, CNT_W + 1);
        chk({tag, " buzzer_in_calc"}, bad, 0);
        chk({tag, " half_period"}, half_period, h);
        r = 0;
        while (buzzer !== 1'b1 && r < lim) begin
            @(negedge clk);
            r++;
        end
        chk({tag, " first_rise"}, r, h);
        p = 0;
        while (buzzer === 1'b1 && p < lim) begin
            @(negedge clk);
            p++;
        end
        while (buzzer === 1'b0 && p < lim) begin
            @(negedge clk);
            p++;
        end
        chk({tag, " period"}, p, 2 * h);
    endtask

    initial begin
        int highs;
        int r;
        int f;
        int prev;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset buzzer", buzzer, 0);
        chk("reset busy", busy, 0);
        chk("reset half_period", half_period, 0);

        run_note("f523", 523);
        run_note("f1000_restart", 1000);

        // Change mid-CALC restarts the divider
        frequency = 12'd262;
        repeat (10) @(negedge clk);
        chk("abort busy_mid_calc", busy, 1);
        run_note("f4095_after_abort", 4095);
        chk("abort stale_half_seen", saw_stale_half, 0);

        // Silence
        frequency = '0;
        @(negedge clk);
        chk("silence buzzer", buzzer, 0);
        chk("silence busy", busy, 0);
        chk("silence half_retained", half_period, model_half(4095));
        highs = 0;
        repeat (300) begin
            @(negedge clk);
            if (buzzer !== 1'b0) highs++;
        end
        chk("silence buzzer_highs", highs, 0);
        run_note("f1000_after_silence", 1000);

        // Mute for 3000 cycles mid-play, then re-enable
        repeat (200) @(negedge clk);
        enable = 1'b0;
        highs = 0;
        repeat (3000) begin
            @(negedge clk);
            if (buzzer !== 1'b0) highs++;
        end
        chk("mute buzzer_highs", highs, 0);
        enable = 1'b1;
        r = 0;
        while (buzzer !== 1'b1 && r < 4000) begin
            @(negedge clk);
            r++;
        end
        chk("unmute first_rise", r, model_half(1000));

        // Asynchronous reset during CALC
        @(negedge clk);
        frequency = 12'd440;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst buzzer", buzzer, 0);
        chk("async_rst busy", busy, 0);
        chk("async_rst half_period", half_period, 0);
        @(negedge clk);
        rst = 1'b0;
        run_note("f440_after_reset", 440);

        // Same value after silence must restart the phase
        frequency = '0;
        repeat (5) @(negedge clk);
        run_note("f440_same_after_silence", 440);

        // Randomized notes
        prev = 440;
        for (int i = 0; i < 4; i++) begin
            f = int'($urandom_range(300, 4095));
            if (f == prev) f = (f == 4095) ? 300 : f + 1;
            run_note($sformatf("rand%0d_f%0d", i, f), f);
            prev = f;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
